// File: rtl/ps2_scan_port.sv
// PS/2 keyboard receiver with a scan-code FIFO exposed as a single 32-bit CPU port word.
// Frames are sampled on synchronized ps2_clk falling edges; valid codes are queued in arrival order.
module ps2_scan_port #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        io_rd,
  output logic [31:0] rdata,
  output logic        overflow,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  logic [2:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  state_e        state_q;
  logic [3:0]    bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          push_q;
  logic [7:0]    push_data_q;
  logic          frame_err_q;
  logic          overflow_q;
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [7:0]    mem [FIFO_DEPTH];

  logic ps2_fall;
  logic ps2_bit;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;

  assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign ps2_bit  = data_sync_q[1];

  // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q     <= '0;
          bit_cnt_q <= '0;
          if (ps2_fall && !ps2_bit) begin
            state_q   <= SHIFT;
            bit_cnt_q <= 4'd1;
          end
        end
        SHIFT: begin
          if (ps2_fall) begin
            tmo_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q <= 4'd8) begin
              shift_q <= {ps2_bit, shift_q[7:1]};
            end else if (bit_cnt_q == 4'd9) begin
              parity_q <= ps2_bit;
            end else begin
              // Stop bit: odd parity over data+parity and a high stop bit make a good frame.
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              if ((^shift_q ^ parity_q) && ps2_bit) begin
                push_q      <= 1'b1;
                push_data_q <= shift_q;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = io_rd & ~fifo_empty;
  assign push_ok    = push_q & (~fifo_full | pop);

  // NOTE: storage has no reset; clearing the pointers is what empties the FIFO.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push_q && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign rdata     = fifo_empty ? 32'd0 : {1'b1, 23'd0, mem[rd_ptr_q[AW-1:0]]};
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_port.sv
// Scoreboard bench for ps2_scan_port: the stimulus queues expected codes, a monitor pops and
// compares them whenever it loads the port word.
module tb_ps2_scan_port;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 20;

  logic        clk      = 1'b0;
  logic        clrn     = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic        io_rd    = 1'b0;
  logic [31:0] rdata;
  logic        overflow;
  logic        frame_err;

  ps2_scan_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .io_rd    (io_rd),
    .rdata    (rdata),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          err_seen = 0;
  int          err_exp  = 0;
  logic        ovf_exp  = 1'b0;
  bit          rd_auto  = 1'b0;
  int unsigned rd_cycle = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: owns io_rd, counts frame_err pulses, and checks every loaded word against the queue.
  initial begin
    forever begin
      @(negedge clk);
      io_rd = 1'b0;
      if (frame_err) err_seen++;
      if (!clrn) continue;
      if (!rdata[31]) check("rdata_idle_zero", rdata, 32'd0);
      if (rd_auto || cyc == rd_cycle) begin
        io_rd = 1'b1;
        if (rdata[31]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_code", rdata, 32'd0);
          end else begin
            check("read_code", rdata, {1'b1, 23'd0, exp_q[0]});
            void'(exp_q.pop_front());
          end
        end else if (!rd_auto && exp_q.size() != 0) begin
          check("read_missing", rdata, {1'b1, 23'd0, exp_q[0]});
        end
      end
    end
  end

  task automatic ps2_bit(input logic d, input bit coinc, input bit lat_chk);
    int k;
    ps2_data = d;
    wait_neg(HALF);
    ps2_clk = 1'b0;
    // Sync (2) + edge flop + push cycle: the push lands on the 4th rising edge after this drive.
    if (coinc) rd_cycle = cyc + 3;
    if (lat_chk) begin
      k = 0;
      while (!rdata[31] && k < 5) begin
        wait_neg(1);
        k++;
      end
      check("latency_ready", {31'd0, rdata[31]}, 32'd1);
      wait_neg(HALF - k);
    end else begin
      wait_neg(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int nbits, input bit coinc, input bit lat_chk);
    logic        p;
    logic [10:0] f;
    p = ~(^b) ^ par_bad;
    f = {~stop_bad, p, b, 1'b0};
    if (nbits == 11) begin
      if (par_bad || stop_bad) err_exp++;
      else if (exp_q.size() < DEPTH || coinc) exp_q.push_back(b);
      else ovf_exp = 1'b1;
    end
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], coinc && i == 10, lat_chk && i == 10);
    ps2_data = 1'b1;
    wait_neg(4);
  endtask

  task automatic do_read();
    rd_cycle = cyc + 1;
    wait_neg(2);
  endtask

  task automatic do_reset();
    wait_neg(1);
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_neg(3);
    check("rst_rdata", rdata, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    exp_q.delete();
    ovf_exp = 1'b0;
    clrn = 1'b1;
    wait_neg(3);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int         mode;

    wait_neg(3);
    check("init_rdata", rdata, 32'd0);
    check("init_overflow", {31'd0, overflow}, 32'd0);
    check("init_frame_err", {31'd0, frame_err}, 32'd0);
    clrn = 1'b1;
    wait_neg(5);

    send_frame(8'h1C, 0, 0, 11, 0, 1);
    check("word_1c", rdata, 32'h8000_001C);
    do_read();
    check("after_1c", rdata, 32'd0);

    send_frame(8'hF0, 0, 0, 11, 0, 0);
    send_frame(8'h1C, 0, 0, 11, 0, 0);
    check("head_f0", rdata, 32'h8000_00F0);
    do_read();
    do_read();
    do_read();
    check("after_f0_1c", rdata, 32'd0);

    send_frame(8'h12, 1, 0, 11, 0, 0);
    check("bad_parity_ready", {31'd0, rdata[31]}, 32'd0);
    check("bad_parity_err", err_seen, err_exp);
    send_frame(8'h12, 0, 1, 11, 0, 0);
    check("bad_stop_ready", {31'd0, rdata[31]}, 32'd0);
    check("bad_stop_err", err_seen, err_exp);

    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11, 0, 0);
    check("overflow_set", {31'd0, overflow}, {31'd0, ovf_exp});
    repeat (DEPTH) do_read();
    check("overflow_drained", rdata, 32'd0);
    check("overflow_queue_left", exp_q.size(), 32'd0);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    do_reset();
    for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), 0, 0, 11, 0, 0);
    send_frame(8'h5A, 0, 0, 11, 1, 0);
    check("coinc_no_overflow", {31'd0, overflow}, 32'd0);
    repeat (DEPTH) do_read();
    check("coinc_drained", rdata, 32'd0);
    check("coinc_queue_left", exp_q.size(), 32'd0);

    send_frame(8'h33, 0, 0, 5, 0, 0);
    err_exp++;
    wait_neg(TMO + 10);
    check("timeout_err", err_seen, err_exp);
    check("timeout_ready", {31'd0, rdata[31]}, 32'd0);
    send_frame(8'h29, 0, 0, 11, 0, 0);
    check("after_timeout_29", rdata, 32'h8000_0029);
    do_read();

    send_frame(8'h00, 0, 0, 4, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) ps2_bit(1'b1, 0, 0);
    wait_neg(4);
    check("mid_reset_ready", {31'd0, rdata[31]}, 32'd0);
    check("mid_reset_err", err_seen, err_exp);
    send_frame(8'h29, 0, 0, 11, 0, 0);
    check("mid_reset_29", rdata, 32'h8000_0029);
    do_read();

    rd_auto = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom);
      mode = int'($urandom_range(0, 5));
      send_frame(rb, mode == 0, mode == 1, 11, 0, 0);
    end
    wait_neg(20);
    rd_auto = 1'b0;
    wait_neg(2);
    check("random_drained", exp_q.size(), 32'd0);
    check("random_err", err_seen, err_exp);
    check("random_overflow", {31'd0, overflow}, {31'd0, ovf_exp});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
